// File: rtl/weight_ram_arbiter_if.sv
// rtl/weight_ram_arbiter_if.sv - bus bundle between the requesters, the weight RAM arbiter and the RAM port
//
// Purpose: groups the loader, read driver, RAM port and status signals of
// weight_ram_arbiter. The arbiter uses the slave modport. The requesters, the
// RAM primitive and any status observer share the master modport.
//
// Signals:
//   ld_req, ld_addr, ld_data, ld_last  loader write offer
//   ld_gnt                             loader owns the RAM
//   rd_req, rd_addr                    read driver request
//   rd_gnt, rd_data, rd_valid          read driver grant and returned data
//   ram_en, ram_we, ram_addr, ram_din  RAM control and write path
//   ram_dout                           RAM read data, one-cycle latency
//   loaded, load_count                 load status
interface weight_ram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_gnt;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              loaded;
  logic [ADDR_W:0]   load_count;

  modport slave (
    input  ld_req, ld_addr, ld_data, ld_last, rd_req, rd_addr, ram_dout,
    output ld_gnt, rd_gnt, rd_data, rd_valid, ram_en, ram_we, ram_addr,
           ram_din, loaded, load_count
  );

  modport master (
    output ld_req, ld_addr, ld_data, ld_last, rd_req, rd_addr, ram_dout,
    input  ld_gnt, rd_gnt, rd_data, rd_valid, ram_en, ram_we, ram_addr,
           ram_din, loaded, load_count
  );
endinterface

// File: rtl/weight_ram_arbiter.sv
// rtl/weight_ram_arbiter.sv - single-port weight RAM arbiter between the loader and the read driver
//
// Purpose: owns the weight block RAM port and hands it to either the host
// weight loader (burst-locked writes) or the read driver (streaming reads).
// Every change of owner passes through IDLE, giving one turnaround cycle.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    weight_ram_arbiter_if.slave (requesters, RAM port, load status)
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined: a tie in IDLE goes to the requester that was
//                       not granted most recently (loader wins the first tie).
//                       undefined: the loader wins every tie.
module weight_ram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024
) (
  input logic                 clk,
  input logic                 reset,
  weight_ram_arbiter_if.slave bus
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

  state_t            state;
  state_t            state_nx;
  logic              ld_wr;
  logic              rd_go;
  logic              loader_wins;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_hold;
  logic              loaded_q;
  logic [CNT_W-1:0]  count_q;

  assign ld_wr = (state == LOAD) && bus.ld_req;
  assign rd_go = (state == READ) && bus.rd_req;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 when the loader held the most recent grant; reset value means READ.
  logic last_owner_ld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_ld <= 1'b0;
    end else if (state == IDLE && state_nx == LOAD) begin
      last_owner_ld <= 1'b1;
    end else if (state == IDLE && state_nx == READ) begin
      last_owner_ld <= 1'b0;
    end
  end

  assign loader_wins = !last_owner_ld;
`else
  assign loader_wins = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.ld_req && bus.rd_req) begin
          state_nx = loader_wins ? LOAD : READ;
        end else if (bus.ld_req) begin
          state_nx = LOAD;
        end else if (bus.rd_req) begin
          state_nx = READ;
        end
      end
      // The loader keeps the RAM through gaps in ld_req until it writes ld_last.
      LOAD:    if (ld_wr && bus.ld_last) state_nx = IDLE;
      READ:    if (!bus.rd_req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // RAM pins see only the granted requester; address and data are zero when idle.
  always_comb begin
    bus.ld_gnt   = (state == LOAD);
    bus.rd_gnt   = (state == READ);
    bus.ram_en   = 1'b0;
    bus.ram_we   = 1'b0;
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    if (ld_wr) begin
      bus.ram_en   = 1'b1;
      bus.ram_we   = 1'b1;
      bus.ram_addr = bus.ld_addr;
      bus.ram_din  = bus.ld_data;
    end else if (rd_go) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = bus.rd_addr;
    end
  end

  // The RAM already registers its output, so the word for a read issued in
  // cycle N is on ram_dout in cycle N+1 alongside rd_valid. rd_hold keeps the
  // last delivered word so rd_data stays stable while rd_valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_hold    <= '0;
    end else begin
      rd_valid_q <= rd_go;
      if (rd_valid_q) rd_hold <= bus.ram_dout;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_valid_q ? bus.ram_dout : rd_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loaded_q <= 1'b0;
      count_q  <= '0;
    end else if (ld_wr) begin
      if (bus.ld_last) loaded_q <= 1'b1;
      if (count_q != COUNT_MAX) count_q <= count_q + 1'b1;
    end
  end

  assign bus.loaded     = loaded_q;
  assign bus.load_count = count_q;
endmodule
